// File: rtl/freq_meter_sched.sv
// freq_meter_sched: measurement scheduler for the frequency meter.
// Runs a repeating WAIT/GATE cycle, counts rising edges of clk_test inside the
// gate and hands each result to the display path over a valid/ready handshake.
// Optional auto-ranging between a long (Hz) and short (kHz) gate is enabled by
// defining FREQ_METER_AUTORANGE_EN; without it the long gate is always used.
module freq_meter_sched #(
    parameter logic [27:0] GATE_LONG_MAX  = 28'd49_999_999,
    parameter logic [27:0] GATE_SHORT_MAX = 28'd49_999,
    parameter logic [27:0] IDLE_MAX       = 28'd12_499_999,
    parameter logic [23:0] DISP_MAX       = 24'd999_999,
    parameter logic [23:0] DOWN_TH        = 24'd900
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        clk_test,
    input  logic        meas_en,
    input  logic        data_ready,
    output logic [23:0] data,
    output logic        unit,
    output logic        ovf,
    output logic        data_valid,
    output logic        gate_busy
);

`ifdef FREQ_METER_AUTORANGE_EN
    localparam bit AUTORANGE = 1'b1;
`else
    localparam bit AUTORANGE = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_GATE,
        ST_CALC,
        ST_HOLD
    } state_t;

    state_t      state;
    logic        s0;
    logic        s1;
    logic        s2;
    logic        rise;
    logic        rng;
    logic [27:0] cyc_cnt;
    logic [23:0] edge_cnt;
    logic [27:0] gate_max;

    assign rise     = s1 & ~s2;
    assign gate_max = rng ? GATE_SHORT_MAX : GATE_LONG_MAX;

    // Bring the asynchronous test signal into sys_clk; s2 is the edge-detect history tap.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s0 <= 1'b0;
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s0 <= clk_test;
            s1 <= s0;
            s2 <= s1;
        end
    end

    // Range register: steps up on a Hz overflow, steps back down on a sparse kHz count.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rng <= 1'b0;
        end else if (AUTORANGE && state == ST_CALC) begin
            if (!rng && edge_cnt > DISP_MAX) begin
                rng <= 1'b1;
            end else if (rng && edge_cnt < DOWN_TH) begin
                rng <= 1'b0;
            end
        end
    end

    // Scheduler FSM with counters and registered result/handshake outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= ST_IDLE;
            cyc_cnt    <= 28'd0;
            edge_cnt   <= 24'd0;
            data       <= 24'd0;
            unit       <= 1'b0;
            ovf        <= 1'b0;
            data_valid <= 1'b0;
            gate_busy  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (meas_en) begin
                        state    <= ST_WAIT;
                        cyc_cnt  <= 28'd0;
                        edge_cnt <= 24'd0;
                    end
                end
                ST_WAIT: begin
                    if (!meas_en) begin
                        state   <= ST_IDLE;
                        cyc_cnt <= 28'd0;
                    end else if (cyc_cnt == IDLE_MAX) begin
                        state     <= ST_GATE;
                        cyc_cnt   <= 28'd0;
                        gate_busy <= 1'b1;
                    end else begin
                        cyc_cnt <= cyc_cnt + 28'd1;
                    end
                end
                ST_GATE: begin
                    if (!meas_en) begin
                        // Abort: the partial count is simply left to be cleared on the next WAIT.
                        state     <= ST_IDLE;
                        cyc_cnt   <= 28'd0;
                        gate_busy <= 1'b0;
                    end else begin
                        if (rise && edge_cnt != 24'hFF_FFFF) begin
                            edge_cnt <= edge_cnt + 24'd1;
                        end
                        if (cyc_cnt == gate_max) begin
                            state     <= ST_CALC;
                            cyc_cnt   <= 28'd0;
                            gate_busy <= 1'b0;
                        end else begin
                            cyc_cnt <= cyc_cnt + 28'd1;
                        end
                    end
                end
                ST_CALC: begin
                    // Saturate to the display limit; unit reports the range this gate used.
                    if (edge_cnt > DISP_MAX) begin
                        data <= DISP_MAX;
                        ovf  <= 1'b1;
                    end else begin
                        data <= edge_cnt;
                        ovf  <= 1'b0;
                    end
                    unit       <= rng;
                    data_valid <= 1'b1;
                    state      <= ST_HOLD;
                end
                ST_HOLD: begin
                    // The handshake always completes before meas_en is honoured.
                    if (data_ready) begin
                        data_valid <= 1'b0;
                        if (meas_en) begin
                            state    <= ST_WAIT;
                            edge_cnt <= 24'd0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_meter_sched.sv
// Testbench for freq_meter_sched using small gate/idle lengths.
// Expected results are queued when the test signal is programmed and
// compared when the scheduler presents them on data_valid.
module tb_freq_meter_sched;

    localparam logic [27:0] T_GATE_LONG  = 28'd119;
    localparam logic [27:0] T_GATE_SHORT = 28'd11;
    localparam logic [27:0] T_IDLE       = 28'd4;
    localparam logic [23:0] T_DISP       = 24'd30;
    localparam logic [23:0] T_DOWN       = 24'd3;

    logic        sys_clk    = 1'b0;
    logic        sys_rst_n  = 1'b0;
    logic        clk_test   = 1'b0;
    logic        meas_en    = 1'b0;
    logic        data_ready = 1'b1;
    logic [23:0] data;
    logic        unit;
    logic        ovf;
    logic        data_valid;
    logic        gate_busy;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic [23:0] data;
        logic        unit;
        logic        ovf;
        int          gate_len;
    } exp_t;

    exp_t sb[$];

    int period  = 10;
    bit restart = 1'b0;
    int tcnt    = 0;

    freq_meter_sched #(
        .GATE_LONG_MAX (T_GATE_LONG),
        .GATE_SHORT_MAX(T_GATE_SHORT),
        .IDLE_MAX      (T_IDLE),
        .DISP_MAX      (T_DISP),
        .DOWN_TH       (T_DOWN)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clk_test  (clk_test),
        .meas_en   (meas_en),
        .data_ready(data_ready),
        .data      (data),
        .unit      (unit),
        .ovf       (ovf),
        .data_valid(data_valid),
        .gate_busy (gate_busy)
    );

    always #5 sys_clk = ~sys_clk;

    // Test-signal generator: one rising edge per 'period' sys_clk cycles, restartable.
    always begin
        @(negedge sys_clk);
        #1;
        if (restart) begin
            tcnt    = 0;
            restart = 1'b0;
        end else if (tcnt >= period - 1) begin
            tcnt = 0;
        end else begin
            tcnt = tcnt + 1;
        end
        clk_test = (tcnt < period / 2);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic set_period(input int p);
        period  = p;
        restart = 1'b1;
    endtask

    task automatic push_exp(input logic [23:0] d, input logic u, input logic o, input int g);
        exp_t e;
        e.data     = d;
        e.unit     = u;
        e.ovf      = o;
        e.gate_len = g;
        sb.push_back(e);
    endtask

    // Wait (bounded) for the next result; returns at the negedge where data_valid is seen.
    task automatic collect_result(output logic [23:0] d, output logic u, output logic o,
                                  output int cycles, output int gate_cnt, output bit ok);
        cycles   = 0;
        gate_cnt = 0;
        ok       = 1'b0;
        d        = 24'd0;
        u        = 1'b0;
        o        = 1'b0;
        while (cycles < 2000 && !ok) begin
            @(negedge sys_clk);
            cycles = cycles + 1;
            if (gate_busy === 1'b1) gate_cnt = gate_cnt + 1;
            if (data_valid === 1'b1) begin
                ok = 1'b1;
                d  = data;
                u  = unit;
                o  = ovf;
            end
        end
        if (!ok) begin
            tests_run    = tests_run + 1;
            tests_failed = tests_failed + 1;
            $display("FAIL result_timeout: data_valid=0 after %0d cycles, required 1", cycles);
        end
    endtask

    task automatic test_reset();
        sys_rst_n  = 1'b0;
        meas_en    = 1'b0;
        data_ready = 1'b1;
        set_period(10);
        repeat (3) @(negedge sys_clk);
        tests_run++;
        if (data !== 24'd0) begin tests_failed++; $display("FAIL reset_data: got %0d, required 0", data); end
        tests_run++;
        if (unit !== 1'b0) begin tests_failed++; $display("FAIL reset_unit: got %b, required 0", unit); end
        tests_run++;
        if (ovf !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf: got %b, required 0", ovf); end
        tests_run++;
        if (data_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b, required 0", data_valid); end
        tests_run++;
        if (gate_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b, required 0", gate_busy); end
        sys_rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);
    endtask

    task automatic test_basic();
        logic [23:0] d;
        logic        u;
        logic        o;
        int          cyc;
        int          gcnt;
        bit          ok;
        exp_t        e;
        @(negedge sys_clk);
        meas_en = 1'b1;
        push_exp(24'd12, 1'b0, 1'b0, 120);
        collect_result(d, u, o, cyc, gcnt, ok);
        if (ok) begin
            e = sb.pop_front();
            // Edge 1 leaves IDLE, then 5 WAIT + 120 GATE + 1 CALC edges.
            tests_run++;
            if (cyc !== 127) begin tests_failed++; $display("FAIL basic_latency: valid after %0d edges, required 127", cyc); end
            tests_run++;
            if (gcnt !== e.gate_len) begin tests_failed++; $display("FAIL basic_gate_len: got %0d, required %0d", gcnt, e.gate_len); end
            tests_run++;
            if (d !== e.data) begin tests_failed++; $display("FAIL basic_data: got %0d, required %0d", d, e.data); end
            tests_run++;
            if (u !== e.unit) begin tests_failed++; $display("FAIL basic_unit: got %b, required %b", u, e.unit); end
            tests_run++;
            if (o !== e.ovf) begin tests_failed++; $display("FAIL basic_ovf: got %b, required %b", o, e.ovf); end
        end
    endtask

    task automatic test_autorange();
        logic [23:0] d;
        logic        u;
        logic        o;
        int          cyc;
        int          gcnt;
        bit          ok;
        exp_t        e;
        int          nres;
        sb.delete();
        sys_rst_n = 1'b0;
        meas_en   = 1'b0;
        set_period(3);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        meas_en = 1'b1;
`ifdef FREQ_METER_AUTORANGE_EN
        nres = 4;
        push_exp(24'd30, 1'b0, 1'b1, 120);
        push_exp(24'd4, 1'b1, 1'b0, 12);
`else
        nres = 3;
        push_exp(24'd30, 1'b0, 1'b1, 120);
        push_exp(24'd30, 1'b0, 1'b1, 120);
        push_exp(24'd30, 1'b0, 1'b1, 120);
`endif
        for (int i = 0; i < nres; i++) begin
            collect_result(d, u, o, cyc, gcnt, ok);
            if (!ok) break;
            e = sb.pop_front();
            tests_run++;
            if (gcnt !== e.gate_len) begin tests_failed++; $display("FAIL range_gate_len[%0d]: got %0d, required %0d", i, gcnt, e.gate_len); end
            tests_run++;
            if (d !== e.data) begin tests_failed++; $display("FAIL range_data[%0d]: got %0d, required %0d", i, d, e.data); end
            tests_run++;
            if (u !== e.unit) begin tests_failed++; $display("FAIL range_unit[%0d]: got %b, required %b", i, u, e.unit); end
            tests_run++;
            if (o !== e.ovf) begin tests_failed++; $display("FAIL range_ovf[%0d]: got %b, required %b", i, o, e.ovf); end
`ifdef FREQ_METER_AUTORANGE_EN
            // Slow the signal so a short gate sees one edge, then fall back to Hz.
            if (i == 1) begin
                set_period(12);
                push_exp(24'd1, 1'b1, 1'b0, 12);
            end else if (i == 2) begin
                set_period(10);
                push_exp(24'd12, 1'b0, 1'b0, 120);
            end
`endif
        end
    endtask

    task automatic test_backpressure();
        logic [23:0] d;
        logic        u;
        logic        o;
        int          cyc;
        int          gcnt;
        bit          ok;
        int          bad;
        exp_t        e;
        @(posedge sys_clk);
        @(negedge sys_clk);
        data_ready = 1'b0;
        set_period(10);
        push_exp(24'd12, 1'b0, 1'b0, 120);
        collect_result(d, u, o, cyc, gcnt, ok);
        if (ok) begin
            e = sb.pop_front();
            tests_run++;
            if (d !== e.data) begin tests_failed++; $display("FAIL bp_data: got %0d, required %0d", d, e.data); end
            tests_run++;
            if (u !== e.unit || o !== e.ovf) begin tests_failed++; $display("FAIL bp_flags: got unit=%b ovf=%b, required unit=%b ovf=%b", u, o, e.unit, e.ovf); end
            tests_run++;
            if (gcnt !== e.gate_len) begin tests_failed++; $display("FAIL bp_gate_len: got %0d, required %0d", gcnt, e.gate_len); end
            bad = 0;
            for (int i = 0; i < 50; i++) begin
                @(negedge sys_clk);
                if (data_valid !== 1'b1 || data !== d || gate_busy !== 1'b0) bad++;
            end
            tests_run++;
            if (bad !== 0) begin tests_failed++; $display("FAIL bp_hold_stable: %0d unstable cycles, required 0", bad); end
            data_ready = 1'b1;
            @(posedge sys_clk);
            #1;
            tests_run++;
            if (data_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_valid_fall: got %b, required 0", data_valid); end
            repeat (4) @(posedge sys_clk);
            #1;
            tests_run++;
            if (gate_busy !== 1'b0) begin tests_failed++; $display("FAIL bp_wait_len: gate_busy=%b after 4 WAIT edges, required 0", gate_busy); end
            @(posedge sys_clk);
            #1;
            tests_run++;
            if (gate_busy !== 1'b1) begin tests_failed++; $display("FAIL bp_gate_start: gate_busy=%b after 5 WAIT edges, required 1", gate_busy); end
        end
    endtask

    task automatic test_abort();
        int bad;
        int waited;
        repeat (59) @(posedge sys_clk);
        @(negedge sys_clk);
        meas_en = 1'b0;
        @(posedge sys_clk);
        #1;
        tests_run++;
        if (gate_busy !== 1'b0) begin tests_failed++; $display("FAIL abort_busy: got %b, required 0", gate_busy); end
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge sys_clk);
            if (data_valid !== 1'b0 || gate_busy !== 1'b0 || data !== 24'd12) bad++;
        end
        tests_run++;
        if (bad !== 0) begin tests_failed++; $display("FAIL abort_quiet: %0d cycles with activity or changed data, required 0", bad); end

        // Restart and hit the asynchronous reset in the middle of a gate.
        meas_en = 1'b1;
        waited  = 0;
        while (gate_busy !== 1'b1 && waited < 50) begin
            @(negedge sys_clk);
            waited++;
        end
        tests_run++;
        if (gate_busy !== 1'b1) begin tests_failed++; $display("FAIL rst_gate_start: gate_busy=%b after %0d cycles, required 1", gate_busy, waited); end
        repeat (10) @(negedge sys_clk);
        #2;
        sys_rst_n = 1'b0;
        #1;
        tests_run++;
        if (data !== 24'd0) begin tests_failed++; $display("FAIL async_rst_data: got %0d, required 0", data); end
        tests_run++;
        if (gate_busy !== 1'b0) begin tests_failed++; $display("FAIL async_rst_busy: got %b, required 0", gate_busy); end
        tests_run++;
        if (data_valid !== 1'b0 || unit !== 1'b0 || ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_rst_flags: got valid=%b unit=%b ovf=%b, required 0 0 0", data_valid, unit, ovf);
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        meas_en   = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_autorange();
        test_backpressure();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
